// File: rtl/mant_align.sv
// Mantissa alignment stage: expands the reduced max exponent into per-lane right shifts and
// returns sticky-extended mantissas aligned to it, through a 2-stage valid/ready pipeline.
module mant_align #(
  parameter int N     = 4,
  parameter int WIDTH = 8,
  parameter int MW    = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    in_valid_i,
  output logic                    in_ready_o,
  input  logic [N-1:0][WIDTH:0]   exp_i,
  input  logic [WIDTH:0]          max_exp_i,
  input  logic [N-1:0][MW-1:0]    mant_i,
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
  output logic [N-1:0][MW:0]      aligned_o,
  output logic [WIDTH:0]          max_exp_o,
  output logic [N-1:0]            err_o
);

  localparam int SW = $clog2(MW + 1);
  localparam logic [WIDTH+1:0] MW_D = (WIDTH + 2)'(MW);
  localparam logic [SW-1:0]    MW_S = SW'(MW);

  // Handshake: a beat moves on a rising edge when valid & ready on that side.
  // s2 advances when empty or drained; s1 advances when empty or s2 advances;
  // in_ready is that s1 advance (no skid), held low until one cycle after reset.
  logic r_rdy_en;
  logic r_s1_valid;
  logic r_s2_valid;
  logic w_s2_adv;
  logic w_s1_adv;
  logic w_in_fire;

  logic [N-1:0][SW-1:0]    r_s1_shift;
  logic [N-1:0][MW-1:0]    r_s1_mant;
  logic [WIDTH:0]          r_s1_max;
  logic [N-1:0]            r_s1_err;

  logic [N-1:0][WIDTH+1:0] w_diff;
  logic [N-1:0][SW-1:0]    w_shift;
  logic [N-1:0]            w_err;
  logic [N-1:0][MW-1:0]    w_keep;
  logic [N-1:0][MW:0]      w_aligned;

  logic [N-1:0][MW:0]      r_aligned;
  logic [WIDTH:0]          r_max_out;
  logic [N-1:0]            r_err_out;

  assign w_s2_adv    = !r_s2_valid || out_ready_i;
  assign w_s1_adv    = !r_s1_valid || w_s2_adv;
  assign in_ready_o  = w_s1_adv && r_rdy_en;
  assign w_in_fire   = in_valid_i && in_ready_o;
  assign out_valid_o = r_s2_valid;
  assign aligned_o   = r_aligned;
  assign max_exp_o   = r_max_out;
  assign err_o       = r_err_out;

  // Difference is formed one bit wider than the exponents so max - exp never wraps.
  always_comb begin
    w_diff  = '0;
    w_shift = '0;
    w_err   = '0;
    for (int i = 0; i < N; i++) begin
      w_diff[i] = {max_exp_i[WIDTH], max_exp_i} - {exp_i[i][WIDTH], exp_i[i]};
      if (w_diff[i][WIDTH+1]) begin
        w_err[i]   = 1'b1;
        w_shift[i] = '0;
      end else if (w_diff[i] >= MW_D) begin
        w_shift[i] = MW_S;
      end else begin
        w_shift[i] = SW'(w_diff[i]);
      end
    end
  end

  // w_keep marks bits that survive the shift; everything else feeds sticky.
  always_comb begin
    w_keep    = '0;
    w_aligned = '0;
    for (int i = 0; i < N; i++) begin
      w_keep[i]    = {MW{1'b1}} << r_s1_shift[i];
      w_aligned[i] = {r_s1_mant[i] >> r_s1_shift[i], |(r_s1_mant[i] & ~w_keep[i])};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rdy_en   <= 1'b0;
      r_s1_valid <= 1'b0;
      r_s1_shift <= '0;
      r_s1_mant  <= '0;
      r_s1_max   <= '0;
      r_s1_err   <= '0;
    end else begin
      r_rdy_en <= 1'b1;
      if (w_s1_adv) r_s1_valid <= w_in_fire;
      if (w_in_fire) begin
        r_s1_shift <= w_shift;
        r_s1_mant  <= mant_i;
        r_s1_max   <= max_exp_i;
        r_s1_err   <= w_err;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_s2_valid <= 1'b0;
      r_aligned  <= '0;
      r_max_out  <= '0;
      r_err_out  <= '0;
    end else begin
      if (w_s2_adv) r_s2_valid <= r_s1_valid;
      if (w_s2_adv && r_s1_valid) begin
        r_aligned <= w_aligned;
        r_max_out <= r_s1_max;
        r_err_out <= r_s1_err;
      end
    end
  end

endmodule

// File: tb/tb_mant_align.sv
// Bench for mant_align (N=4, WIDTH=8, MW=8): directed and random beats, scoreboard on the output handshake.
module tb_mant_align;

  localparam int N     = 4;
  localparam int WIDTH = 8;
  localparam int MW    = 8;
  localparam int EW    = N * (MW + 1) + (WIDTH + 1) + N;

  logic                  clk;
  logic                  rst_n;
  logic                  in_valid;
  logic                  in_ready;
  logic [N-1:0][WIDTH:0] exp_in;
  logic [WIDTH:0]        max_in;
  logic [N-1:0][MW-1:0]  mant_in;
  logic                  out_valid;
  logic                  out_ready;
  logic [N-1:0][MW:0]    aligned;
  logic [WIDTH:0]        max_out;
  logic [N-1:0]          err;

  logic [EW-1:0] exp_q[$];
  int n_tests;
  int n_fail;
  int n_out;

  mant_align #(.N(N), .WIDTH(WIDTH), .MW(MW)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .exp_i       (exp_in),
    .max_exp_i   (max_in),
    .mant_i      (mant_in),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .aligned_o   (aligned),
    .max_exp_o   (max_out),
    .err_o       (err)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [EW-1:0] model(input logic [N-1:0][WIDTH:0] e,
                                          input logic [WIDTH:0] m,
                                          input logic [N-1:0][MW-1:0] mt);
    logic [N-1:0][MW:0] al;
    logic [N-1:0]       er;
    int d;
    int sh;
    logic st;
    al = '0;
    er = '0;
    for (int i = 0; i < N; i++) begin
      d     = int'($signed(m)) - int'($signed(e[i]));
      er[i] = (d < 0);
      sh    = (d < 0) ? 0 : ((d > MW) ? MW : d);
      st    = 1'b0;
      for (int b = 0; b < MW; b++) begin
        if (b < sh) st = st | mt[i][b];
        else        al[i][b - sh + 1] = mt[i][b];
      end
      al[i][0] = st;
    end
    return {al, m, er};
  endfunction

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (rst_n) begin
      if (out_valid && out_ready) begin
        n_out++;
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL sb_unexpected: got %h, required no beat", {aligned, max_out, err});
        end else begin
          e = exp_q.pop_front();
          if ({aligned, max_out, err} !== e) begin
            n_fail++;
            $display("FAIL sb_beat: got %h, required %h", {aligned, max_out, err}, e);
          end
        end
      end
      if (in_valid && in_ready) exp_q.push_back(model(exp_in, max_in, mant_in));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_all(input logic [WIDTH:0] e, input logic [WIDTH:0] m, input logic [MW-1:0] mt);
    for (int i = 0; i < N; i++) begin
      exp_in[i]  = e;
      mant_in[i] = mt;
    end
    max_in = m;
  endtask

  task automatic set_random_beat();
    max_in = (WIDTH + 1)'($urandom_range(0, 511));
    for (int i = 0; i < N; i++) begin
      if ($urandom_range(0, 15) == 0) exp_in[i] = max_in + (WIDTH + 1)'($urandom_range(1, 4));
      else                            exp_in[i] = max_in - (WIDTH + 1)'($urandom_range(0, 11));
      mant_in[i] = MW'($urandom);
    end
  endtask

  // Raises in_valid and returns #1 after the edge that accepted the beat.
  task automatic wait_accept();
    int cyc;
    cyc = 0;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    n_tests++;
    if (!in_ready) begin
      n_fail++;
      $display("FAIL accept_timeout: in_ready %b, required 1 within 100 cycles", in_ready);
    end
    @(posedge clk);
    #1;
  endtask

  // Sends one beat, then returns #1 after the edge where out_valid rises.
  task automatic send_and_wait();
    int cyc;
    wait_accept();
    in_valid = 1'b0;
    cyc = 0;
    while (!out_valid && cyc < 20) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    n_tests++;
    if (!out_valid) begin
      n_fail++;
      $display("FAIL out_timeout: out_valid %b, required 1", out_valid);
    end
  endtask

  task automatic drain();
    int cyc;
    out_ready = 1'b1;
    in_valid  = 1'b0;
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 50) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if (exp_q.size() != 0 || out_valid) begin
      n_fail++;
      $display("FAIL drain: pending %0d out_valid %b, required 0 0", exp_q.size(), out_valid);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    set_all('0, '0, '0);
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if ({out_valid, in_ready, aligned, max_out, err} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h, required 0", {out_valid, in_ready, aligned, max_out, err});
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_tests++;
    if (in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ready_early: in_ready %b, required 0", in_ready);
    end
    @(posedge clk);
    #1;
    n_tests++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ready_after: in_ready %b, required 1", in_ready);
    end
  endtask

  task automatic test_basic();
    logic [N-1:0][MW:0] exp_al;
    exp_al[0] = 9'h1FE; exp_al[1] = 9'h07F; exp_al[2] = 9'h1FE; exp_al[3] = 9'h003;
    out_ready = 1'b1;
    exp_in[0] = 9'd5; exp_in[1] = 9'd3; exp_in[2] = 9'd5; exp_in[3] = 9'h1FE;
    max_in = 9'd5;
    for (int i = 0; i < N; i++) mant_in[i] = 8'hFF;
    wait_accept();
    in_valid = 1'b0;
    n_tests++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_latency_early: out_valid %b, required 0", out_valid);
    end
    @(posedge clk);
    #1;
    n_tests++;
    if (out_valid !== 1'b1 || aligned !== exp_al || err !== 4'b0000 || max_out !== 9'd5) begin
      n_fail++;
      $display("FAIL basic: valid %b aligned %h err %b max %h, required 1 %h 0000 005",
               out_valid, aligned, err, max_out, exp_al);
    end
    drain();
  endtask

  task automatic test_saturate();
    out_ready = 1'b1;
    set_all(9'h100, 9'h0FF, 8'h80);
    send_and_wait();
    n_tests++;
    if (aligned !== {N{9'h001}} || err !== 4'b0000) begin
      n_fail++;
      $display("FAIL sat_511_80: aligned %h err %b, required all 001 0000", aligned, err);
    end
    set_all(9'h100, 9'h0FF, 8'h00);
    send_and_wait();
    n_tests++;
    if (aligned !== {N{9'h000}}) begin
      n_fail++;
      $display("FAIL sat_511_00: aligned %h, required all 000", aligned);
    end
    set_all(9'h1FD, 9'd5, 8'h01);
    send_and_wait();
    n_tests++;
    if (aligned !== {N{9'h001}}) begin
      n_fail++;
      $display("FAIL sat_mw: aligned %h, required all 001", aligned);
    end
    drain();
  endtask

  task automatic test_bad_max();
    out_ready = 1'b1;
    set_all(9'd5, 9'd5, 8'hAA);
    exp_in[0] = 9'd6;
    send_and_wait();
    n_tests++;
    if (err !== 4'b0001 || aligned[0] !== 9'h154 || aligned[1] !== 9'h154) begin
      n_fail++;
      $display("FAIL bad_max: err %b lane0 %h lane1 %h, required 0001 154 154", err, aligned[0], aligned[1]);
    end
    set_all(9'h0FF, 9'h100, 8'h3C);
    send_and_wait();
    n_tests++;
    if (err !== 4'b1111 || aligned !== {N{9'h078}} || max_out !== 9'h100) begin
      n_fail++;
      $display("FAIL bad_max_extreme: err %b aligned %h max %h, required 1111 all 078 100", err, aligned, max_out);
    end
    drain();
  endtask

  task automatic test_backpressure();
    logic [EW-1:0] snap;
    out_ready = 1'b0;
    set_random_beat();
    wait_accept();
    set_random_beat();
    wait_accept();
    set_random_beat();
    @(negedge clk);
    snap = {aligned, max_out, err};
    n_tests++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_full: in_ready %b out_valid %b, required 0 1", in_ready, out_valid);
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_tests++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || {aligned, max_out, err} !== snap) begin
        n_fail++;
        $display("FAIL bp_hold: in_ready %b out_valid %b data %h, required 0 1 %h",
                 in_ready, out_valid, {aligned, max_out, err}, snap);
      end
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    #1;
    n_tests++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_simul: in_ready %b, required 1 when full and out_ready", in_ready);
    end
    wait_accept();
    set_random_beat();
    wait_accept();
    set_random_beat();
    wait_accept();
    drain();
  endtask

  task automatic test_back_to_back();
    int start;
    int stalls;
    int early;
    out_ready = 1'b1;
    start = n_out;
    stalls = 0;
    early = 0;
    in_valid = 1'b1;
    for (int k = 0; k < 20; k++) begin
      set_random_beat();
      @(negedge clk);
      if (!in_ready) stalls++;
      if ((k >= 2) != out_valid) early++;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    n_tests++;
    if (stalls != 0 || early != 0) begin
      n_fail++;
      $display("FAIL b2b_flow: stalls %0d valid_errs %0d, required 0 0", stalls, early);
    end
    drain();
    n_tests++;
    if (n_out - start != 20) begin
      n_fail++;
      $display("FAIL b2b_count: got %0d beats, required 20", n_out - start);
    end
  endtask

  task automatic test_reset_midflight();
    int start;
    out_ready = 1'b1;
    set_random_beat();
    wait_accept();
    set_random_beat();
    wait_accept();
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (out_valid !== 1'b0 || aligned !== '0 || err !== '0 || max_out !== '0 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid: valid %b aligned %h err %b max %h ready %b, required all 0",
               out_valid, aligned, err, max_out, in_ready);
    end
    exp_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    start = n_out;
    set_all(9'd4, 9'd6, 8'h0F);
    wait_accept();
    in_valid = 1'b0;
    n_tests++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_stale: out_valid %b, required 0", out_valid);
    end
    @(posedge clk);
    #1;
    n_tests++;
    if (out_valid !== 1'b1 || aligned !== {N{9'h007}}) begin
      n_fail++;
      $display("FAIL rst_next: valid %b aligned %h, required 1 all 007", out_valid, aligned);
    end
    drain();
    n_tests++;
    if (n_out - start != 1) begin
      n_fail++;
      $display("FAIL rst_count: got %0d beats, required 1", n_out - start);
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    n_out   = 0;
    test_reset();
    test_basic();
    test_saturate();
    test_bad_max();
    test_backpressure();
    test_back_to_back();
    test_reset_midflight();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
